// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: stall-cause encoding,
// mult/div counter width and the register-address width helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_RAW    = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_MD     = 2'd3
  } stall_cause_e;

  localparam int MD_CNT_W = 8;

  // Address width for n registers, never less than one bit.
  function automatic int reg_aw(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the unit latency on issue and counts
// down to zero; the reset clears it asynchronously.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  output logic [MD_CNT_W-1:0] cnt
);

  localparam logic [MD_CNT_W-1:0] LAT_V = MD_CNT_W'(MD_LAT);

  logic [MD_CNT_W-1:0] cnt_r;
  logic [MD_CNT_W-1:0] cnt_nxt_s;

  // Next count: reload on issue, otherwise count down and rest at zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = LAT_V;
    end else if (cnt_r != {MD_CNT_W{1'b0}}) begin
      cnt_nxt_s = cnt_r - MD_CNT_W'(1);
    end else begin
      cnt_nxt_s = {MD_CNT_W{1'b0}};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {MD_CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: long-latency scoreboard, branch and mult/div stalls,
// E-stage forwarding. Define HAZARD_SB_PERF_EN to build the stall counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MD_LAT   = 32,
  parameter int REG_AW   = reg_aw(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic [REG_AW-1:0] write_reg_d,
  input  logic              long_lat_d,
  input  logic              branch_d,
  input  logic              md_start_d,
  input  logic              hilo_read_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic              reg_write_e,
  input  logic              long_lat_e,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [REG_AW-1:0] write_reg_wb,
  input  logic              reg_write_m,
  input  logic              reg_write_wb,
  input  logic              wb_long_done,
  input  logic              flush_in,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic [1:0]        forwardA_e,
  output logic [1:0]        forwardB_e,
  output logic              md_busy,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       md_stall_cycles
);

  localparam logic [REG_AW-1:0]   REG_ZERO = {REG_AW{1'b0}};
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] NOT_R0   = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic [NUM_REGS-1:0] set_s, clr_wb_s, clr_fl_s;
  logic [MD_CNT_W-1:0] md_cnt_s;
  logic                issue_s, raw_stall_s, br_stall_s, md_stall_s, md_busy_s;
  logic                stall_s;
  stall_cause_e        cause_s;

  assign issue_s = ~stall_s;

  // Set wins over clear because the set mask is OR-ed in last.
  assign set_s    = (issue_s && long_lat_d && (write_reg_d != REG_ZERO)) ?
                    (ONE_HOT0 << write_reg_d) : {NUM_REGS{1'b0}};
  assign clr_wb_s = wb_long_done ? (ONE_HOT0 << write_reg_wb) : {NUM_REGS{1'b0}};
  assign clr_fl_s = (flush_in && long_lat_e) ? (ONE_HOT0 << write_reg_e) : {NUM_REGS{1'b0}};
  assign pend_nxt_s = ((pend_r & ~clr_wb_s & ~clr_fl_s) | set_s) & NOT_R0;

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= {NUM_REGS{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  md_busy_counter #(
    .MD_LAT(MD_LAT)
  ) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (issue_s && md_start_d),
    .cnt   (md_cnt_s)
  );

  assign md_busy_s   = (md_cnt_s != {MD_CNT_W{1'b0}});
  assign raw_stall_s = (uses_rs_d && pend_r[rs_d]) || (uses_rt_d && pend_r[rt_d]);
  assign br_stall_s  = branch_d && reg_write_e && (write_reg_e != REG_ZERO) &&
                       ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign md_stall_s  = md_busy_s && (hilo_read_d || md_start_d);

  // Priority-encoded stall cause.
  always_comb begin
    cause_s = CAUSE_NONE;
    if (raw_stall_s) begin
      cause_s = CAUSE_RAW;
    end else if (br_stall_s) begin
      cause_s = CAUSE_BRANCH;
    end else if (md_stall_s) begin
      cause_s = CAUSE_MD;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  // Branch inputs are raw decode signals, so gate with reset to keep stalls low.
  assign stall_s = rst_n && (cause_s != CAUSE_NONE);
  assign stall_f = stall_s;
  assign stall_d = stall_s;
  assign flush_e = stall_s || flush_in;
  assign md_busy = md_busy_s;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    if ((r != REG_ZERO) && (r == write_reg_m) && reg_write_m) begin
      sel = 2'b10;
    end else if ((r != REG_ZERO) && (r == write_reg_wb) && reg_write_wb) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign forwardA_e = fwd_sel(rs_e);
  assign forwardB_e = fwd_sel(rt_e);

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] stall_cnt_r, md_stall_cnt_r;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r    <= 32'd0;
      md_stall_cnt_r <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (md_stall_s && (md_stall_cnt_r != 32'hFFFF_FFFF)) begin
        md_stall_cnt_r <= md_stall_cnt_r + 32'd1;
      end
    end
  end

  assign stall_cycles    = stall_cnt_r;
  assign md_stall_cycles = md_stall_cnt_r;
`else
  assign stall_cycles    = 32'd0;
  assign md_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (MD_LAT=4): a reference model
// pushes expected observations to a queue, popped and compared per cycle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, write_reg_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_wb;
  logic       uses_rs_d, uses_rt_d, long_lat_d, branch_d, md_start_d, hilo_read_d;
  logic       reg_write_e, long_lat_e, reg_write_m, reg_write_wb, wb_long_done, flush_in;
  logic       stall_f, stall_d, flush_e, md_busy;
  logic [1:0] forwardA_e, forwardB_e;
  logic [31:0] stall_cycles, md_stall_cycles;

  typedef struct packed {
    logic        stall_f;
    logic        stall_d;
    logic        flush_e;
    logic        md_busy;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] msc;
  } obs_t;

  obs_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  bit          m_pend[32];
  int          m_md;
  int unsigned m_sc, m_msc;

  hazard_scoreboard #(.NUM_REGS(32), .MD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rt_d(rt_d), .uses_rs_d(uses_rs_d), .uses_rt_d(uses_rt_d),
    .write_reg_d(write_reg_d), .long_lat_d(long_lat_d), .branch_d(branch_d),
    .md_start_d(md_start_d), .hilo_read_d(hilo_read_d),
    .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .long_lat_e(long_lat_e),
    .write_reg_m(write_reg_m), .write_reg_wb(write_reg_wb),
    .reg_write_m(reg_write_m), .reg_write_wb(reg_write_wb),
    .wb_long_done(wb_long_done), .flush_in(flush_in),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .forwardA_e(forwardA_e), .forwardB_e(forwardB_e), .md_busy(md_busy),
    .stall_cycles(stall_cycles), .md_stall_cycles(md_stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit m_raw_br();
    bit raw, br;
    raw = (uses_rs_d && m_pend[rs_d]) || (uses_rt_d && m_pend[rt_d]);
    br  = branch_d && reg_write_e && (write_reg_e != 5'd0) &&
          ((write_reg_e == rs_d) || (write_reg_e == rt_d));
    return raw || br;
  endfunction

  function automatic bit m_mds();
    return (m_md != 0) && (hilo_read_d || md_start_d);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r != 5'd0 && r == write_reg_m && reg_write_m) return 2'b10;
    if (r != 5'd0 && r == write_reg_wb && reg_write_wb) return 2'b01;
    return 2'b00;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    bit   st;
    st        = rst_n && (m_raw_br() || m_mds());
    o.stall_f = st;
    o.stall_d = st;
    o.flush_e = st || flush_in;
    o.md_busy = (m_md != 0);
    o.fa      = m_fwd(rs_e);
    o.fb      = m_fwd(rt_e);
`ifdef HAZARD_SB_PERF_EN
    o.sc  = m_sc;
    o.msc = m_msc;
`else
    o.sc  = 32'd0;
    o.msc = 32'd0;
`endif
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {stall_f, stall_d, flush_e, md_busy, forwardA_e, forwardB_e,
         stall_cycles, md_stall_cycles};
    return o;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_md = 0; m_sc = 0; m_msc = 0;
  endtask

  task automatic clear_inputs();
    rs_d = 5'd0; rt_d = 5'd0; write_reg_d = 5'd0; rs_e = 5'd0; rt_e = 5'd0;
    write_reg_e = 5'd0; write_reg_m = 5'd0; write_reg_wb = 5'd0;
    uses_rs_d = 1'b0; uses_rt_d = 1'b0; long_lat_d = 1'b0; branch_d = 1'b0;
    md_start_d = 1'b0; hilo_read_d = 1'b0; reg_write_e = 1'b0; long_lat_e = 1'b0;
    reg_write_m = 1'b0; reg_write_wb = 1'b0; wb_long_done = 1'b0; flush_in = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs held before the edge.
  task automatic step();
    bit st, mds;
    mds = m_mds();
    st  = m_raw_br() || mds;
    if (rst_n) begin
      if (st && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (mds && m_msc != 32'hFFFF_FFFF) m_msc++;
      if (wb_long_done) m_pend[write_reg_wb] = 1'b0;
      if (flush_in && long_lat_e) m_pend[write_reg_e] = 1'b0;
      if (!st && long_lat_d && write_reg_d != 5'd0) m_pend[write_reg_d] = 1'b1;
      if (!st && md_start_d) m_md = 4;
      else if (m_md != 0) m_md--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t g, e;
    rst_n = 1'b0;
    model_clear();
    clear_inputs();
    flush_in = 1'b1; rs_e = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1;
    branch_d = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd4; rs_d = 5'd4;
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e) begin n_bad++; $display("FAIL reset got=%h exp=%h", g, e); end
    step();
    clear_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    obs_t g, e;
    clear_inputs();
    long_lat_d = 1'b1; write_reg_d = 5'd5;
    step();
    clear_inputs();
    uses_rs_d = 1'b1; rs_d = 5'd5;
    for (int i = 0; i < 5; i++) begin
      wb_long_done = (i == 3); write_reg_wb = (i == 3) ? 5'd5 : 5'd0;
      exp_q.push_back(model_obs());
      #1;
      g = dut_obs(); e = exp_q.pop_front(); n_total++;
      if (g !== e) begin n_bad++; $display("FAIL load_use[%0d] got=%h exp=%h", i, g, e); end
      n_total++;
      if (stall_d !== (i <= 3)) begin
        n_bad++; $display("FAIL load_use_stall[%0d] got=%b exp=%b", i, stall_d, (i <= 3));
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    obs_t g, e;
    clear_inputs();
    long_lat_d = 1'b1; write_reg_d = 5'd7;
    step();
    clear_inputs();
    long_lat_e = 1'b1; write_reg_e = 5'd7; reg_write_e = 1'b1; flush_in = 1'b1;
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e) begin n_bad++; $display("FAIL flush_cycle got=%h exp=%h", g, e); end
    step();
    clear_inputs();
    uses_rs_d = 1'b1; rs_d = 5'd7; uses_rt_d = 1'b1; rt_d = 5'd7;
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e || stall_d !== 1'b0) begin
      n_bad++; $display("FAIL flush_consumer got=%h exp=%h", g, e);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_mult_div();
    obs_t g, e;
    int   stalls;
    clear_inputs();
    md_start_d = 1'b1;
    step();
    clear_inputs();
    hilo_read_d = 1'b1;
    stalls = 0;
    for (int c = 1; c <= 6; c++) begin
      exp_q.push_back(model_obs());
      #1;
      g = dut_obs(); e = exp_q.pop_front(); n_total++;
      if (g !== e) begin n_bad++; $display("FAIL md_cycle[%0d] got=%h exp=%h", c, g, e); end
      if (stall_d) stalls++;
      step();
    end
    n_total++;
    if (stalls !== 4) begin n_bad++; $display("FAIL md_stall_count got=%0d exp=4", stalls); end
    clear_inputs();
  endtask

  task automatic test_forward();
    obs_t g, e;
    logic [4:0] ra[5]  = '{5'd3, 5'd3, 5'd0, 5'd3, 5'd6};
    logic       wm[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exa[5] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
    clear_inputs();
    write_reg_m = 5'd3; write_reg_wb = 5'd3; reg_write_wb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rs_e = ra[i]; rt_e = 5'd3; reg_write_m = wm[i];
      exp_q.push_back(model_obs());
      #1;
      g = dut_obs(); e = exp_q.pop_front(); n_total++;
      if (g !== e || forwardA_e !== exa[i]) begin
        n_bad++; $display("FAIL forward[%0d] got=%h exp=%h fa=%b want=%b", i, g, e, forwardA_e, exa[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    obs_t g, e;
    clear_inputs();
    branch_d = 1'b1; reg_write_e = 1'b1; rt_d = 5'd4; rs_d = 5'd1;
    for (int i = 0; i < 3; i++) begin
      write_reg_e = (i == 0) ? 5'd4 : ((i == 1) ? 5'd0 : 5'd1);
      exp_q.push_back(model_obs());
      #1;
      g = dut_obs(); e = exp_q.pop_front(); n_total++;
      if (g !== e) begin n_bad++; $display("FAIL branch[%0d] got=%h exp=%h", i, g, e); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_collision();
    obs_t g, e;
    clear_inputs();
    long_lat_d = 1'b1; write_reg_d = 5'd9;
    step();
    wb_long_done = 1'b1; write_reg_wb = 5'd9;
    step();
    clear_inputs();
    uses_rs_d = 1'b1; rs_d = 5'd9;
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e || stall_d !== 1'b1) begin
      n_bad++; $display("FAIL collision got=%h exp=%h", g, e);
    end
    wb_long_done = 1'b1; write_reg_wb = 5'd9;
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    obs_t g, e;
    clear_inputs();
    long_lat_d = 1'b1; write_reg_d = 5'd12;
    step();
    clear_inputs();
    md_start_d = 1'b1;
    step();
    clear_inputs();
    hilo_read_d = 1'b1; uses_rs_d = 1'b1; rs_d = 5'd12;
    #2;
    rst_n = 1'b0;
    model_clear();
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e || md_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got=%h exp=%h", g, e);
    end
    step();
    rst_n = 1'b1;
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e) begin n_bad++; $display("FAIL reset_mid_after got=%h exp=%h", g, e); end
    step();
    clear_inputs();
  endtask

  task automatic test_perf();
    obs_t g, e;
    do_reset();
    branch_d = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd4; rs_d = 5'd4;
    for (int i = 0; i < 10; i++) step();
    clear_inputs();
    exp_q.push_back(model_obs());
    #1;
    g = dut_obs(); e = exp_q.pop_front(); n_total++;
    if (g !== e) begin n_bad++; $display("FAIL perf got=%h exp=%h", g, e); end
    n_total++;
`ifdef HAZARD_SB_PERF_EN
    if (stall_cycles !== 32'd10) begin
      n_bad++; $display("FAIL perf_stall_cycles got=%0d exp=10", stall_cycles);
    end
`else
    if (stall_cycles !== 32'd0) begin
      n_bad++; $display("FAIL perf_stall_cycles got=%0d exp=0", stall_cycles);
    end
`endif
  endtask

  initial begin
    clear_inputs();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_flush();
    test_mult_div();
    test_forward();
    test_branch();
    test_collision();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 32, is the architectural register count; REG_AW = clog2(NUM_REGS).
REQ-002 Parameter MD_LAT, default 32, is the mult/div latency in cycles (1..255).
REQ-003 Ports:
  clk  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  rs_d, rt_d  in  REG_AW  decode source registers.
  uses_rs_d, uses_rt_d  in  1  decode instruction reads rs/rt.
  write_reg_d  in  REG_AW  decode destination.
  long_lat_d  in  1  decode result comes from memory or C0.
  branch_d  in  1  decode branch compares in D.
  md_start_d  in  1  decode is mult/div.
  hilo_read_d  in  1  decode is mfhi/mflo.
  rs_e, rt_e, write_reg_e  in  REG_AW  execute registers.
  reg_write_e, long_lat_e  in  1  execute write enable, execute is long-latency.
  write_reg_m, write_reg_wb  in  REG_AW  memory/writeback destinations.
  reg_write_m, reg_write_wb  in  1  memory/writeback write enables.
  wb_long_done  in  1  long-latency result written back this cycle.
  flush_in  in  1  overflow/exception flush of E.
  stall_f, stall_d, flush_e  out  1  pipeline controls.
  forwardA_e, forwardB_e  out  2  execute operand select.
  md_busy  out  1  mult/div unit busy.
  stall_cycles, md_stall_cycles  out  32  performance counters.

Function
REQ-004 pend[NUM_REGS] scoreboard bits; pend[0] SHALL never be set.
REQ-005 issue = ~stall_d; at a clock edge with issue && long_lat_d && write_reg_d!=0, pend[write_reg_d] SHALL be set.
REQ-006 At a clock edge with wb_long_done, pend[write_reg_wb] SHALL be cleared.
REQ-007 At a clock edge with flush_in && long_lat_e, pend[write_reg_e] SHALL be cleared.
REQ-008 Same-register set and clear in one cycle: set SHALL win.
REQ-009 raw_stall = (uses_rs_d && pend[rs_d]) || (uses_rt_d && pend[rt_d]), combinational from registered pend.
REQ-010 br_stall = branch_d && reg_write_e && write_reg_e!=0 && (write_reg_e==rs_d || write_reg_e==rt_d).
REQ-011 md_cnt (8 bits) SHALL load MD_LAT on issue && md_start_d; otherwise it SHALL decrement when nonzero and hold at 0.
REQ-012 md_busy = (md_cnt != 0); md_stall = md_busy && (hilo_read_d || md_start_d).
REQ-013 stall_f = stall_d = raw_stall || br_stall || md_stall; flush_e = stall_d || flush_in.
REQ-014 forwardA_e SHALL be 2'b10 when rs_e!=0 && rs_e==write_reg_m && reg_write_m; otherwise 2'b01 when rs_e!=0 && rs_e==write_reg_wb && reg_write_wb; otherwise 2'b00. forwardB_e SHALL apply the same rule to rt_e.
REQ-015 flush_in SHALL NOT abort an in-flight mult/div; md_cnt continues.
REQ-016 Stall and forward outputs SHALL be combinational with zero cycle latency; scoreboard and counter updates SHALL take effect the next cycle.

Reset
REQ-017 While rst_n is low: pend = 0, md_cnt = 0, both counters = 0, and all outputs low except those driven by inputs (forwardA_e/forwardB_e, flush_e from flush_in).
REQ-018 A reset mid-mult/div SHALL drop md_busy immediately (asynchronously).

Configuration
REQ-019 With HAZARD_SB_PERF_EN defined: stall_cycles SHALL increment on every cycle stall_d=1, md_stall_cycles SHALL increment on every cycle md_stall=1, and both SHALL saturate at 32'hFFFFFFFF.
REQ-020 With HAZARD_SB_PERF_EN undefined: the ports SHALL remain present and SHALL be tied to 0, with no counter flops.

Structure
REQ-021 The stall-cause encoding and REG_AW helper function SHALL live in shared package hazard_pkg.
REQ-022 Sub-module md_busy_counter SHALL hold md_cnt; the scoreboard SHALL be inline.

Verification
REQ-023 Load-use: lw to r5 issues, next instruction uses rs=5 -> stall_d=1 until the cycle after wb_long_done with write_reg_wb=5, then 0.
REQ-024 Flush cleanup: lw r7 in E with flush_in=1 -> pend[7]=0 next cycle; a consumer of r7 is not stalled.
REQ-025 Mult/div: MD_LAT=4, mult issues at cycle 0, mflo in D -> md_stall for cycles 1-4, released at cycle 5.
REQ-026 Forwarding priority: rs_e=3, write_reg_m=3, write_reg_wb=3, both write enables high -> forwardA_e=2'b10; rs_e=0 -> 2'b00.
REQ-027 Collision: wb_long_done for r9 in the same cycle a new lw r9 issues -> pend[9] stays 1.
REQ-028 Reset and perf: assert rst_n low during a stall -> all pend and counters 0; with HAZARD_SB_PERF_EN defined, 10 stall cycles -> stall_cycles=10.
